// File: rtl/fetch_queue.sv
// Instruction fetch buffer in front of decode.
// Issues sequential word fetches to the icache and buffers the returned words with their PCs.
// It presents the head word as inst and the following word as nextinst, and it owns the
// prev_long_imm flag that decode uses to squash long-immediate words. A redirect flushes the
// queue, restarts fetch at the new PC and drops every response that is still in flight.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        f2ic_req_valid,
   output logic [31:0] f2ic_req_addr,
   input  logic        ic2f_req_ready,
   input  logic        ic2f_resp_valid,
   input  logic [31:0] ic2f_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic        d2f_long_imm,
   output logic        f2d_valid,
   output logic [31:0] f2d_inst,
   output logic [31:0] f2d_nextinst,
   output logic [31:0] f2d_pc,
   output logic        f2d_prev_long_imm
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          prev_long_imm_q, prev_long_imm_d;

   logic [CW:0]   in_use;
   logic          issue;
   logic          push;
   logic          pop;
   logic [31:0]   resp_pc;
   logic [PW-1:0] head_nxt;

   // Requests are throttled so queued plus in-flight words never exceed the queue size;
   // the reset term keeps the request quiet while the block is held in reset.
   assign in_use         = {1'b0, count_q} + {1'b0, outst_q};
   assign f2ic_req_valid = rst_b & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
   assign f2ic_req_addr  = fetch_pc_q;
   assign issue          = f2ic_req_valid & ic2f_req_ready;

   // A response is kept only when no stale words remain to be dropped and no flush is under way.
   assign push    = ic2f_resp_valid & (drop_q == '0) & ~redirect_valid;
   // The PC of a returning word is recovered from the issue PC and the number still in flight.
   assign resp_pc = fetch_pc_q - (32'(outst_q) << 2);

   // Two held words are needed so nextinst is always a real fetched word.
   assign f2d_valid = (count_q >= CW'(2));
   assign pop       = f2d_valid & ~stall;
   assign head_nxt  = head_q + PW'(1);

   assign f2d_inst          = (count_q == '0) ? '0 : data_mem[head_q];
   assign f2d_nextinst      = (count_q == '0) ? '0 : data_mem[head_nxt];
   assign f2d_pc            = (count_q == '0) ? '0 : pc_mem[head_q];
   assign f2d_prev_long_imm = prev_long_imm_q;

   // Next-state for pointers, occupancy, in-flight tracking, fetch PC and the long-imm flag.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      outst_d         = outst_q;
      drop_d          = drop_q;
      fetch_pc_d      = fetch_pc_q;
      prev_long_imm_d = prev_long_imm_q;

      if (redirect_valid) begin
         // Everything still in flight after this cycle's response belongs to the old stream.
         head_d          = '0;
         tail_d          = '0;
         count_d         = '0;
         outst_d         = outst_q - CW'(ic2f_resp_valid);
         drop_d          = outst_q - CW'(ic2f_resp_valid);
         fetch_pc_d      = redirect_pc & ~32'h3;
         prev_long_imm_d = 1'b0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         outst_d = outst_q + CW'(issue) - CW'(ic2f_resp_valid);
         if (ic2f_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            tail_d = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_nxt;
            // The word after a long-imm word is its immediate and is never long itself.
            prev_long_imm_d = d2f_long_imm & ~prev_long_imm_q;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_b) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_b) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         outst_q         <= '0;
         drop_q          <= '0;
         fetch_pc_q      <= RESET_PC;
         prev_long_imm_q <= 1'b0;
      end else begin
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         outst_q         <= outst_d;
         drop_q          <= drop_d;
         fetch_pc_q      <= fetch_pc_d;
         prev_long_imm_q <= prev_long_imm_d;
      end
   end

   // Entry storage: word and PC written at the tail on each accepted response.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count_q gates every read, so stale contents are never used.
      if (push) begin
         data_mem[tail_q] <= ic2f_resp_data;
         pc_mem[tail_q]   <= resp_pc;
      end
   end

   // The request throttle guarantees there is always a free slot for an accepted response.
   assert property (@(posedge clk) disable iff (!rst_b) !(push && (count_q == CW'(DEPTH))));

endmodule
